ins_fetcher: RTL and testbench

INS_FETCHER -- requirements
Module: ins_fetcher

---
 rtl/ins_fetcher.sv | 148 ++++++++++++++
 tb/tb_ins_fetcher.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetcher.sv
// ins_fetcher: instruction fetch front end.
// Issues one fetch at a time to the ICache from the PC register, pushes each
// returned word (with its PC and the predictor's taken hint) into a circular
// instruction queue, and presents the queue head to the dispatcher.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   ic_req_valid/addr   fetch request to ICache (held while waiting)
//   ic_resp_valid/ins   fetched word from ICache
//   pc_cur, ins_cur     current PC and fetched word to the predictor
//   pc_pred, pred_jump  predicted next PC and taken hint from the predictor
//   ins_valid/out/pc/pred_jump, dispatch_ready  queue head to dispatcher
//   rob_flush, rob_target_pc                    redirect from the ROB
module ins_fetcher #(
    parameter int IQ_DEPTH = 16,
    parameter int ADDR_W   = 32,
    parameter int INS_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              ic_req_valid,
    output logic [ADDR_W-1:0] ic_req_addr,
    input  logic              ic_resp_valid,
    input  logic [INS_W-1:0]  ic_resp_ins,
    output logic [ADDR_W-1:0] pc_cur,
    output logic [INS_W-1:0]  ins_cur,
    input  logic [ADDR_W-1:0] pc_pred,
    input  logic              pred_jump,
    output logic              ins_valid,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_pred_jump,
    input  logic              dispatch_ready,
    input  logic              rob_flush,
    input  logic [ADDR_W-1:0] rob_target_pc
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Queue storage; not reset, only entries below count are ever observed.
    logic [INS_W-1:0]  iq_ins_q  [IQ_DEPTH];
    logic [ADDR_W-1:0] iq_pc_q   [IQ_DEPTH];
    logic              iq_jump_q [IQ_DEPTH];

    logic push, pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (rdy) begin
            if (rob_flush) begin
                // Redirect wins over any response or pop in the same cycle.
                state_d = IDLE;
                pc_d    = rob_target_pc;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                pop = (count_q != '0) && dispatch_ready;

                case (state_q)
                    IDLE: begin
                        if (count_q != FULL_CNT) begin
                            state_d = WAIT;
                        end
                    end
                    WAIT: begin
                        // Request is only issued with a free slot and pops
                        // only free more, so a response always fits.
                        if (ic_resp_valid) begin
                            push    = 1'b1;
                            pc_d    = pc_pred;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase

                if (push) begin
                    tail_d = tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            iq_ins_q[tail_q]  <= ic_resp_ins;
            iq_pc_q[tail_q]   <= pc_q;
            iq_jump_q[tail_q] <= pred_jump;
        end
    end

    assign ic_req_valid  = (state_q == WAIT);
    assign ic_req_addr   = pc_q;
    assign pc_cur        = pc_q;
    assign ins_cur       = ic_resp_ins;
    assign ins_valid     = (count_q != '0);
    assign ins_out       = iq_ins_q[head_q];
    assign ins_pc        = iq_pc_q[head_q];
    assign ins_pred_jump = iq_jump_q[head_q];

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher with a 4-entry queue. The ICache model
// answers in the first WAIT cycle with (addr ^ 0x13) unless overridden, and
// the predictor model returns pc_cur + 4 with no jump unless overridden.
module tb_ins_fetcher;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          ic_req_valid;
    logic [AW-1:0] ic_req_addr;
    logic          ic_resp_valid;
    logic [IW-1:0] ic_resp_ins;
    logic [AW-1:0] pc_cur;
    logic [IW-1:0] ins_cur;
    logic [AW-1:0] pc_pred;
    logic          pred_jump;
    logic          ins_valid;
    logic [IW-1:0] ins_out;
    logic [AW-1:0] ins_pc;
    logic          ins_pred_jump;
    logic          dispatch_ready;
    logic          rob_flush;
    logic [AW-1:0] rob_target_pc;

    // Stimulus knobs
    logic          resp_en, force_resp;
    logic          ins_ovr_en, pred_ovr_en, pj_ovr;
    logic [IW-1:0] ins_ovr;
    logic [AW-1:0] pred_ovr;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    assign ic_resp_valid = resp_en & (ic_req_valid | force_resp);
    assign ic_resp_ins   = ins_ovr_en ? ins_ovr : (ic_req_addr ^ 32'h13);
    assign pc_pred       = pred_ovr_en ? pred_ovr : pc_cur + 32'd4;
    assign pred_jump     = pred_ovr_en ? pj_ovr : 1'b0;

    ins_fetcher #(.IQ_DEPTH(4), .ADDR_W(AW), .INS_W(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_ins    (ic_resp_ins),
        .pc_cur         (pc_cur),
        .ins_cur        (ins_cur),
        .pc_pred        (pc_pred),
        .pred_jump      (pred_jump),
        .ins_valid      (ins_valid),
        .ins_out        (ins_out),
        .ins_pc         (ins_pc),
        .ins_pred_jump  (ins_pred_jump),
        .dispatch_ready (dispatch_ready),
        .rob_flush      (rob_flush),
        .rob_target_pc  (rob_target_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; dispatch_ready = 1'b0;
        rob_flush = 1'b0; rob_target_pc = '0;
        resp_en = 1'b1; force_resp = 1'b0;
        ins_ovr_en = 1'b0; ins_ovr = '0;
        pred_ovr_en = 1'b0; pred_ovr = '0; pj_ovr = 1'b0;

        // Reset
        tick(); tick();
        rst = 1'b0;
        check("rst_req_valid", 32'(ic_req_valid), 32'd0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_pc", pc_cur, 32'h0);

        // First fetch: answer 0x13 at PC 0
        tick();
        check("f0_req_valid", 32'(ic_req_valid), 32'd1);
        check("f0_req_addr", ic_req_addr, 32'h0);
        check("f0_ins_cur", ins_cur, 32'h13);
        tick();
        check("f0_ins_valid", 32'(ins_valid), 32'd1);
        check("f0_ins_out", ins_out, 32'h13);
        check("f0_ins_pc", ins_pc, 32'h0);
        check("f0_req_drop", 32'(ic_req_valid), 32'd0);
        tick();
        check("f1_req_addr", ic_req_addr, 32'h4);

        // Fill the 4-entry queue (pushes of 4, 8, 0xC)
        repeat (5) tick();
        force_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_no_req", 32'(ic_req_valid), 32'd0);
        end
        force_resp = 1'b0;
        check("full_head_pc", ins_pc, 32'h0);

        // One pop lets the next sequential fetch go out
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        check("pop_head_pc", ins_pc, 32'h4);
        tick();
        check("refill_req_valid", 32'(ic_req_valid), 32'd1);
        check("refill_req_addr", ic_req_addr, 32'h10);

        // Flush in a response cycle with 3 entries queued
        tick();
        dispatch_ready = 1'b1;
        tick();
        dispatch_ready = 1'b0;
        check("pre_flush_head", ins_pc, 32'h8);
        tick();
        check("pre_flush_wait", 32'(ic_req_valid), 32'd1);
        rob_flush = 1'b1; rob_target_pc = 32'h100;
        tick();
        rob_flush = 1'b0;
        check("flush_ins_valid", 32'(ins_valid), 32'd0);
        check("flush_req_valid", 32'(ic_req_valid), 32'd0);
        check("flush_pc", pc_cur, 32'h100);
        tick();
        check("flush_req_addr", ic_req_addr, 32'h100);

        // Predicted branch at 0x8
        rob_flush = 1'b1; rob_target_pc = 32'h8;
        tick();
        rob_flush = 1'b0;
        check("flush2_ins_valid", 32'(ins_valid), 32'd0);
        tick();
        check("br_req_addr", ic_req_addr, 32'h8);
        ins_ovr_en = 1'b1; ins_ovr = 32'h0400006F;
        pred_ovr_en = 1'b1; pred_ovr = 32'h40; pj_ovr = 1'b1;
        #1;
        check("br_ins_cur", ins_cur, 32'h0400006F);
        tick();
        ins_ovr_en = 1'b0; pred_ovr_en = 1'b0; pj_ovr = 1'b0;
        check("br_ins_valid", 32'(ins_valid), 32'd1);
        check("br_ins_pc", ins_pc, 32'h8);
        check("br_ins_out", ins_out, 32'h0400006F);
        check("br_pred_jump", 32'(ins_pred_jump), 32'd1);
        tick();
        check("br_next_addr", ic_req_addr, 32'h40);

        // rdy low for 3 cycles mid-WAIT with a response present
        rdy = 1'b0; dispatch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req_valid", 32'(ic_req_valid), 32'd1);
            check("stall_req_addr", ic_req_addr, 32'h40);
            check("stall_head_pc", ins_pc, 32'h8);
        end
        rdy = 1'b1; dispatch_ready = 1'b0;
        check("stall_release_req", 32'(ic_req_valid), 32'd1);
        tick();
        check("stall_push_head", ins_pc, 32'h8);
        check("stall_push_pj", 32'(ins_pred_jump), 32'd1);

        // count=2 with simultaneous push and pop, across pointer wrap
        for (int k = 0; k < 5; k++) begin
            tick();
            check("pp_req_addr", ic_req_addr, 32'h44 + 32'(4 * k));
            dispatch_ready = 1'b1;
            tick();
            dispatch_ready = 1'b0;
            check("pp_head_pc", ins_pc, 32'h40 + 32'(4 * k));
            check("pp_head_ins", ins_out, (32'h40 + 32'(4 * k)) ^ 32'h13);
        end

        // Drain with the ICache silent: exactly two entries remain
        resp_en = 1'b0;
        tick();
        check("drain_wait", 32'(ic_req_valid), 32'd1);
        dispatch_ready = 1'b1;
        tick();
        check("drain1_valid", 32'(ins_valid), 32'd1);
        check("drain1_pc", ins_pc, 32'h54);
        tick();
        dispatch_ready = 1'b0;
        check("drain2_valid", 32'(ins_valid), 32'd0);

        // Reset while waiting, with rdy low
        rdy = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; rdy = 1'b1;
        check("wrst_req_valid", 32'(ic_req_valid), 32'd0);
        check("wrst_pc", pc_cur, 32'h0);
        check("wrst_ins_valid", 32'(ins_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
